// File: rtl/gray_pkg.sv
// Shared types and constants for the two-requester Gray-to-binary scheduler.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned N_REQ = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester not served last wins.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  output logic [1:0] grant_c
);

  // last == 1 means requester 1 was served most recently
  always_comb begin
    grant_c = 2'b00;
    if (valid0 && valid1) begin
      grant_c = last ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant_c = 2'b01;
    end else if (valid1) begin
      grant_c = 2'b10;
    end
  end

endmodule

// File: rtl/gray_bin_sched.sv
// Shares one bit-serial Gray-to-binary engine between two requesters.
// Words are converted MSB first, one bit per cycle, result held until consumed.
module gray_bin_sched
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_gray,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_gray,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_id,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               run_q, run_d;
  logic               id_q, id_d;
  logic               last_q, last_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_bin_q, out_bin_d;
  logic               out_id_q, out_id_d;

  logic [1:0]         grant_c;
  logic               accept0_c, accept1_c, run_bit_c;

  rr_arb2 u_arb (
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .last    (last_q),
    .grant_c (grant_c)
  );

  assign accept0_c = req0_valid && ready_q[0];
  assign accept1_c = req1_valid && ready_q[1];
  // Running binary bit: previous binary bit XOR current Gray MSB
  assign run_bit_c = run_q ^ sh_q[WIDTH-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    run_d       = run_q;
    id_d        = id_q;
    last_d      = last_q;
    ready_d     = '0;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_id_d    = out_id_q;

    case (state_q)
      IDLE: begin
        if ((state_q == IDLE) && (accept0_c || accept1_c)) begin
          state_d = CONV;
          cnt_d   = '0;
          run_d   = 1'b0;
          acc_d   = '0;
          id_d    = accept1_c;
          last_d  = accept1_c;
          sh_d    = accept1_c ? req1_gray : req0_gray;
        end
      end
      CONV: begin
        run_d = run_bit_c;
        acc_d = {acc_q[WIDTH-2:0], run_bit_c};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_bin_d   = {acc_q[WIDTH-2:0], run_bit_c};
          out_id_d    = id_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_bin_d   = '0;
          out_id_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is offered for the cycle in which the FSM sits in IDLE
    if (state_d == IDLE) begin
      ready_d = grant_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      acc_q       <= '0;
      run_q       <= 1'b0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      ready_q     <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      run_q       <= run_d;
      id_q        <= id_d;
      last_q      <= last_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_id_q    <= out_id_d;
    end
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign out_valid  = out_valid_q;
  assign out_bin    = out_bin_q;
  assign out_id     = out_id_q;

endmodule

// File: tb/tb_gray_bin_sched.sv
// Self-checking bench for gray_bin_sched at WIDTH=4 against a transaction-level model.
module tb_gray_bin_sched;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, out_ready;
  logic [W-1:0] req0_gray, req1_gray;
  logic         req0_ready, req1_ready, out_valid, out_id;
  logic [W-1:0] out_bin;

  int vectors     = 0;
  int miscompares = 0;
  int last_served = 1;

  always #5 clk = ~clk;

  gray_bin_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_gray  (req0_gray),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_gray  (req1_gray),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_bin    (out_bin),
    .out_id     (out_id),
    .out_ready  (out_ready)
  );

  // Binary value of a Gray word: XOR of all right shifts of the word
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int id);
    id = -1;
    for (int i = 0; i < 20; i++) begin
      if (req0_valid && req0_ready) begin id = 0; return; end
      if (req1_valid && req1_ready) begin id = 1; return; end
      tick();
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    req0_gray = '0; req1_gray = '0;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || out_bin !== 4'b0000 || out_id !== 1'b0)
      begin miscompares++; $display("FAIL reset_out: valid=%b bin=%b id=%b want 0 0000 0", out_valid, out_bin, out_id); end
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      begin miscompares++; $display("FAIL reset_ready: r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    last_served = 1;
    tick();
  endtask

  task automatic test_single();
    int id, cyc;
    req0_gray = 4'b1001; req0_valid = 1'b1;
    wait_ready(id);
    vectors++;
    if (id !== 0) begin miscompares++; $display("FAIL single_grant: got %0d want 0", id); end
    tick();
    req0_valid = 1'b0; req0_gray = W'($urandom);
    wait_out(cyc);
    vectors++;
    if (cyc != W) begin miscompares++; $display("FAIL single_latency: got %0d want %0d", cyc, W); end
    vectors++;
    if (out_bin !== 4'b1110 || out_id !== 1'b0)
      begin miscompares++; $display("FAIL single_result: bin=%b id=%b want 1110 0", out_bin, out_id); end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_bin !== 4'b0000)
      begin miscompares++; $display("FAIL single_pulse: valid=%b bin=%b want 0 0000", out_valid, out_bin); end
    last_served = 0;
  endtask

  task automatic test_tie();
    int id, cyc;
    rst = 1'b1; tick(); rst = 1'b0; last_served = 1;
    req0_gray = 4'b0011; req1_gray = 4'b1101; req0_valid = 1'b1; req1_valid = 1'b1;
    wait_ready(id);
    vectors++;
    if (id !== 1 - last_served) begin miscompares++; $display("FAIL tie_first: got %0d want %0d", id, 1 - last_served); end
    tick(); req0_valid = 1'b0; last_served = 0;
    wait_out(cyc);
    vectors++;
    if (out_bin !== 4'b0010 || out_id !== 1'b0)
      begin miscompares++; $display("FAIL tie_res0: bin=%b id=%b want 0010 0", out_bin, out_id); end
    tick();
    wait_ready(id);
    vectors++;
    if (id !== 1) begin miscompares++; $display("FAIL tie_second: got %0d want 1", id); end
    tick(); last_served = 1;
    req1_valid = 1'b1; req1_gray = 4'b0111;
    req0_valid = 1'b1; req0_gray = 4'b0110;
    wait_out(cyc);
    vectors++;
    if (out_bin !== 4'b1001 || out_id !== 1'b1)
      begin miscompares++; $display("FAIL tie_res1: bin=%b id=%b want 1001 1", out_bin, out_id); end
    tick();
    wait_ready(id);
    vectors++;
    if (id !== 1 - last_served) begin miscompares++; $display("FAIL tie_again: got %0d want %0d", id, 1 - last_served); end
    tick(); req0_valid = 1'b0; last_served = 0;
    wait_out(cyc);
    vectors++;
    if (out_bin !== g2b(4'b0110) || out_id !== 1'b0)
      begin miscompares++; $display("FAIL tie_res2: bin=%b id=%b want %b 0", out_bin, out_id, g2b(4'b0110)); end
    tick();
    wait_ready(id);
    tick(); req1_valid = 1'b0; last_served = 1;
    wait_out(cyc);
    vectors++;
    if (out_bin !== g2b(4'b0111) || out_id !== 1'b1)
      begin miscompares++; $display("FAIL tie_res3: bin=%b id=%b want %b 1", out_bin, out_id, g2b(4'b0111)); end
    tick();
  endtask

  task automatic test_stall();
    int id, cyc;
    out_ready = 1'b0;
    req0_gray = 4'b0000; req0_valid = 1'b1;
    wait_ready(id);
    tick(); req0_valid = 1'b0; last_served = 0;
    req1_valid = 1'b1; req1_gray = 4'b1010;
    wait_out(cyc);
    vectors++;
    if (cyc != W) begin miscompares++; $display("FAIL stall_latency: got %0d want %0d", cyc, W); end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_bin !== 4'b0000 || out_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        begin miscompares++; $display("FAIL stall_hold[%0d]: valid=%b bin=%b id=%b r0=%b r1=%b want 1 0000 0 0 0", i, out_valid, out_bin, out_id, req0_ready, req1_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_clear: valid=%b want 0", out_valid); end
    wait_ready(id);
    vectors++;
    if (id !== 1) begin miscompares++; $display("FAIL stall_heldoff: got %0d want 1", id); end
    tick(); req1_valid = 1'b0; last_served = 1;
    wait_out(cyc);
    vectors++;
    if (out_bin !== g2b(4'b1010) || out_id !== 1'b1)
      begin miscompares++; $display("FAIL stall_next: bin=%b id=%b want %b 1", out_bin, out_id, g2b(4'b1010)); end
    tick();
  endtask

  task automatic test_reset_mid();
    int id, cyc;
    req0_gray = W'($urandom); req0_valid = 1'b1;
    wait_ready(id);
    tick(); req0_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); last_served = 1;
    vectors++;
    if (out_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
      begin miscompares++; $display("FAIL rstmid_state: valid=%b r0=%b r1=%b want 0 0 0", out_valid, req0_ready, req1_ready); end
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_ghost[%0d]: valid=%b want 0", i, out_valid); end
      tick();
    end
    req1_gray = 4'b1101; req1_valid = 1'b1;
    wait_ready(id);
    vectors++;
    if (id !== 1) begin miscompares++; $display("FAIL rstmid_grant: got %0d want 1", id); end
    tick(); req1_valid = 1'b0; last_served = 1;
    wait_out(cyc);
    vectors++;
    if (cyc != W || out_bin !== 4'b1001 || out_id !== 1'b1)
      begin miscompares++; $display("FAIL rstmid_result: cyc=%0d bin=%b id=%b want %0d 1001 1", cyc, out_bin, out_id, W); end
    tick();
  endtask

  task automatic test_input_change();
    int id, cyc;
    logic [W-1:0] g;
    g = W'($urandom);
    req1_gray = g; req1_valid = 1'b1;
    wait_ready(id);
    tick(); req1_valid = 1'b0; last_served = 1;
    for (int i = 0; i < 3; i++) begin
      req1_gray = W'($urandom);
      tick();
    end
    wait_out(cyc);
    vectors++;
    if (out_bin !== g2b(g) || out_id !== 1'b1)
      begin miscompares++; $display("FAIL input_change: bin=%b id=%b want %b 1", out_bin, out_id, g2b(g)); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] stream [3];
    logic [W-1:0] want [3];
    int k_in, k_out, cyc, prev;
    logic acc;
    stream = '{4'b0001, 4'b0011, 4'b0010};
    want   = '{4'b0001, 4'b0010, 4'b0011};
    k_in = 0; k_out = 0; cyc = 0; prev = -1;
    req0_gray = stream[0]; req0_valid = 1'b1;
    while (k_out < 3 && cyc < 80) begin
      if (out_valid) begin
        vectors++;
        if (out_bin !== want[k_out] || out_id !== 1'b0)
          begin miscompares++; $display("FAIL b2b_result[%0d]: bin=%b id=%b want %b 0", k_out, out_bin, out_id, want[k_out]); end
        k_out++;
      end
      acc = req0_valid && req0_ready;
      if (acc) begin
        if (prev >= 0) begin
          vectors++;
          if (cyc - prev != W + 2)
            begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - prev, W + 2); end
        end
        prev = cyc;
        k_in++;
      end
      tick(); cyc++;
      if (acc) begin
        if (k_in < 3) req0_gray = stream[k_in];
        else req0_valid = 1'b0;
      end
    end
    vectors++;
    if (k_out != 3) begin miscompares++; $display("FAIL b2b_count: got %0d want 3", k_out); end
    req0_valid = 1'b0;
    last_served = 0;
    tick();
  endtask

  task automatic test_random();
    int id, cyc, mode, n, exp_first, exp_id, stall;
    logic [W-1:0] g0, g1;
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 2);
      g0 = W'($urandom); g1 = W'($urandom);
      n = (mode == 2) ? 2 : 1;
      req0_gray = g0; req1_gray = g1;
      req0_valid = (mode != 1); req1_valid = (mode != 0);
      exp_first = (mode == 0) ? 0 : (mode == 1) ? 1 : 1 - last_served;
      for (int k = 0; k < n; k++) begin
        exp_id = (k == 0) ? exp_first : 1 - exp_first;
        wait_ready(id);
        vectors++;
        if (id !== exp_id) begin miscompares++; $display("FAIL rand_grant[%0d.%0d]: got %0d want %0d", it, k, id, exp_id); end
        tick();
        if (id == 0) req0_valid = 1'b0;
        else if (id == 1) req1_valid = 1'b0;
        last_served = exp_id;
        stall = $urandom_range(0, 3);
        out_ready = (stall == 0);
        wait_out(cyc);
        vectors++;
        if (cyc != W || out_bin !== g2b(exp_id == 1 ? g1 : g0) || out_id !== exp_id[0])
          begin miscompares++; $display("FAIL rand_result[%0d.%0d]: cyc=%0d bin=%b id=%b want %0d %b %0d", it, k, cyc, out_bin, out_id, W, g2b(exp_id == 1 ? g1 : g0), exp_id); end
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_bin !== 4'b0000)
          begin miscompares++; $display("FAIL rand_clear[%0d.%0d]: valid=%b bin=%b want 0 0000", it, k, out_valid, out_bin); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    req0_gray = '0; req1_gray = '0;
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_reset_mid();
    test_input_change();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_bin_sched.md
GRAY_BIN_SCHED -- requirements
Module: gray_bin_sched

Interface
REQ-001 Parameter: WIDTH, default 8, Gray/binary word width; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has a Gray word to convert.
REQ-005 Port: req0_gray  input  WIDTH  requester 0 Gray word.
REQ-006 Port: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 Port: req1_valid / req1_gray / req1_ready SHALL mirror REQ-004..006 for requester 1.
REQ-008 Port: out_valid  output  1  converted result available.
REQ-009 Port: out_bin  output  WIDTH  binary result.
REQ-010 Port: out_id  output  1  index of the requester that owns out_bin.
REQ-011 Port: out_ready  input  1  consumer accepts result.

Function
REQ-012 The block SHALL share one bit-serial Gray-to-binary engine between two requesters: b[MSB]=g[MSB], b[i]=b[i+1]^g[i], one bit per cycle, MSB first.
REQ-013 FSM states: IDLE, CONV, DONE; IDLE->CONV on accept, CONV->DONE after last bit, DONE->IDLE on out_valid&&out_ready.
REQ-014 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high together.
REQ-015 Grant: single valid requester wins; both valid -> requester not served last (round-robin); last-served pointer resets to 1 so req0 wins the first tie.
REQ-016 Accept occurs on an edge with reqN_valid&&reqN_ready; reqN_gray SHALL be registered at that edge; later input changes have no effect.
REQ-017 out_valid SHALL rise exactly WIDTH edges after the accept edge (WIDTH=4: accept edge E, out_valid high after E+4).
REQ-018 In DONE, out_valid, out_bin, out_id SHALL hold stable until out_ready; out_ready low stalls indefinitely, no new accept.
REQ-019 After result handshake the FSM returns to IDLE; next accept earliest on following edge (one bubble cycle per word).
REQ-020 out_ready outside DONE SHALL be ignored; reqN_valid during CONV/DONE SHALL be held off (ready low), not lost.
REQ-021 out_bin SHALL read as 0 whenever out_valid is low.

Reset
REQ-022 On rst high at an edge: state=IDLE, out_valid=0, out_bin=0, out_id=0, bit counter=0, last-served pointer=1, both ready low in that cycle.
REQ-023 rst during CONV or DONE SHALL discard the in-flight word; no out_valid for it after reset.
REQ-024 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-025 Shared package gray_pkg SHALL hold the FSM state typedef (IDLE, CONV, DONE) and the requester-count constant (2).
REQ-026 Arbitration SHALL live in sub-module rr_arb2 (inputs: two valids, last-served pointer; output: one-hot grant); engine and FSM stay in gray_bin_sched.
REQ-027 Bit counter width SHALL be $clog2(WIDTH); no combinational path from reqN_gray to out_bin.

Verification (WIDTH=4)
REQ-028 req0 only, gray=1001, out_ready=1 -> out_bin=1110, out_id=0, out_valid 4 edges after accept, high 1 cycle.
REQ-029 req0=0011 and req1=1101 valid same cycle after reset -> req0 served first (0010, id 0), then req1 (1001, id 1); next tie goes to req0 again only after req1 served.
REQ-030 gray=0000 with out_ready=0 for 10 cycles -> out_valid held, out_bin=0000 stable, both ready low, then one handshake clears it.
REQ-031 rst asserted mid-CONV -> out_valid stays 0, state IDLE next cycle, new req1 word 1101 then converts to 1001 normally.
REQ-032 req1_gray changed during CONV -> result reflects word sampled at accept only.
REQ-033 Back-to-back req0 stream 0001,0011,0010 -> results 0001,0010,0011, one bubble cycle between each accept.
